// File: rtl/log_calc_arbiter.sv
// Round-robin front end sharing one log_calc pipeline between NUM_CH requesters.
// Results come back in issue order, each tagged with its source channel.
module log_calc_arbiter #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*32-1:0]        req_power,
  output logic [NUM_CH-1:0]           req_ready,
  output logic                        calc_valid_in,
  output logic [31:0]                 calc_power,
  input  logic                        calc_valid_out,
  input  logic [31:0]                 calc_dbm,
  output logic                        res_valid,
  output logic [CH_W-1:0]             res_ch,
  output logic [31:0]                 res_dbm,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        tag_err
);

  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic {S_DRAIN, S_RUN} state_t;

  state_t             r_state;
  logic [DRN_W-1:0]   r_drain_cnt;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_calc_valid;
  logic [31:0]        r_calc_power;
  logic               r_res_valid;
  logic [CH_W-1:0]    r_res_ch;
  logic [31:0]        r_res_dbm;
  logic               r_tag_err;
  logic [CH_W-1:0]    r_tag_mem [TAG_DEPTH];

  logic               w_run;
  logic               w_credit;
  logic [NUM_CH-1:0]  w_grant;
  logic               w_found;
  logic [CH_W-1:0]    w_idx;
  logic [CH_W-1:0]    w_gnt_idx;
  logic [31:0]        w_gnt_power;
  logic               w_push;
  logic               w_pop;
  logic               w_orphan;

  assign w_run    = (r_state == S_RUN);
  assign w_credit = (r_count < CNT_W'(TAG_DEPTH));

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_rr_ptr) + k) % NUM_CH);
      if (!w_found && req_valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_idx   = '0;
    w_gnt_power = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx   = CH_W'(i);
        w_gnt_power = req_power[32*i +: 32];
      end
    end
  end

  assign req_ready = (w_run && w_credit) ? w_grant : '0;
  assign w_push    = |(req_valid & req_ready);
  assign w_pop     = w_run && calc_valid_out && (r_count != '0);
  assign w_orphan  = w_run && calc_valid_out && (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_DRAIN;
      r_drain_cnt  <= DRN_W'(DRAIN_CYCLES);
      r_rr_ptr     <= CH_W'(NUM_CH - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_calc_valid <= 1'b0;
      r_calc_power <= '0;
      r_res_valid  <= 1'b0;
      r_res_ch     <= '0;
      r_res_dbm    <= '0;
      r_tag_err    <= 1'b0;
    end else begin
      // Drain window covers stale output from the unreset pipeline.
      case (r_state)
        S_DRAIN: begin
          if (r_drain_cnt <= DRN_W'(1)) r_state <= S_RUN;
          if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DRN_W'(1);
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_DRAIN;
      endcase

      r_calc_valid <= w_push;
      if (w_push) begin
        r_calc_power <= w_gnt_power;
        r_rr_ptr     <= w_gnt_idx;
        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
      end

      r_res_valid <= w_pop;
      if (w_pop) begin
        r_res_ch  <= r_tag_mem[r_rd_ptr];
        r_res_dbm <= calc_dbm;
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      end

      if (w_orphan) r_tag_err <= 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_gnt_idx;
  end

  assign calc_valid_in = r_calc_valid;
  assign calc_power    = r_calc_power;
  assign res_valid     = r_res_valid;
  assign res_ch        = r_res_ch;
  assign res_dbm       = r_res_dbm;
  assign outstanding   = r_count;
  assign tag_err       = r_tag_err;

endmodule

// File: tb/tb_log_calc_arbiter.sv
// Directed bench for log_calc_arbiter with a variable-latency log_calc stub (returns power+1)
// and a scoreboard queue of expected {channel, dBm} results.
module tb_log_calc_arbiter;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] dbm;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_power;
  logic [3:0]   req_ready;
  logic         calc_valid_in;
  logic [31:0]  calc_power;
  logic         calc_valid_out;
  logic [31:0]  calc_dbm;
  logic         res_valid;
  logic [1:0]   res_ch;
  logic [31:0]  res_dbm;
  logic [3:0]   outstanding;
  logic         tag_err;

  int           n_checks;
  int           n_fail;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [31:0]  pow [4];

  logic         pv [32];
  logic [31:0]  pd [32];
  int           lat;
  logic         flush;
  logic         inj;

  log_calc_arbiter #(.NUM_CH(4), .CH_W(2), .TAG_DEPTH(8), .DRAIN_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_power(req_power), .req_ready(req_ready),
    .calc_valid_in(calc_valid_in), .calc_power(calc_power),
    .calc_valid_out(calc_valid_out), .calc_dbm(calc_dbm),
    .res_valid(res_valid), .res_ch(res_ch), .res_dbm(res_dbm),
    .outstanding(outstanding), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // log_calc stand-in: no reset, latency 'lat', dBm = power + 1
  always @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < 32; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= 32'd0;
      end
    end else begin
      for (int i = 31; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= calc_valid_in;
      pd[0] <= calc_power + 32'd1;
    end
  end
  assign calc_valid_out = pv[lat-1] | inj;
  assign calc_dbm       = pd[lat-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      check("res_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("res_ch", 32'(res_ch), 32'(mon_e.ch));
        check("res_dbm", res_dbm, mon_e.dbm);
      end
    end
  end

  // One cycle: drive valids, check ready, record expected result of any handshake.
  task automatic step(input logic [3:0] vld, input logic [3:0] exp_rdy, input string nm);
    req_valid = vld;
    #1;
    check(nm, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++)
      if (vld[i] && exp_rdy[i]) exp_q.push_back('{ch: 2'(i), dbm: pow[i] + 32'd1});
    @(negedge clk);
  endtask

  task automatic set_lat(input int l);
    flush = 1'b1;
    lat   = l;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},     32'(req_ready), 32'd0);
    check({pfx, "_calc_valid_in"}, 32'(calc_valid_in), 32'd0);
    check({pfx, "_calc_power"},    calc_power, 32'd0);
    check({pfx, "_res_valid"},     32'(res_valid), 32'd0);
    check({pfx, "_res_ch"},        32'(res_ch), 32'd0);
    check({pfx, "_res_dbm"},       res_dbm, 32'd0);
    check({pfx, "_outstanding"},   32'(outstanding), 32'd0);
    check({pfx, "_tag_err"},       32'(tag_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    pow[0]    = 32'h10;
    pow[1]    = 32'h20;
    pow[2]    = 32'h30;
    pow[3]    = 32'h40;
    req_power = {pow[3], pow[2], pow[1], pow[0]};
    req_valid = 4'b0000;
    inj       = 1'b0;
    flush     = 1'b1;
    lat       = 3;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_reset_outputs("reset");

    // Drain: 16 cycles of no ready; stray calc_valid_out at cycle 5 ignored
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inj = (i == 5);
      step(4'b1111, 4'b0000, "drain_ready");
    end
    inj = 1'b0;
    check("drain_tag_err", 32'(tag_err), 32'd0);

    // Round robin, latency 3
    step(4'b1111, 4'b0001, "rr_grant");
    check("issue_valid", 32'(calc_valid_in), 32'd1);
    check("issue_power", calc_power, 32'h10);
    step(4'b1111, 4'b0010, "rr_grant");
    step(4'b1111, 4'b0100, "rr_grant");
    step(4'b1111, 4'b1000, "rr_grant");
    step(4'b1111, 4'b0001, "rr_grant");
    step(4'b1111, 4'b0010, "rr_grant");
    step(4'b1111, 4'b0100, "rr_grant");
    step(4'b1111, 4'b1000, "rr_grant");
    step(4'b0000, 4'b0000, "rr_idle");
    wait_idle("rr_drain");

    // Sparse requests with wraparound
    step(4'b0100, 4'b0100, "sparse_ch2");
    step(4'b0010, 4'b0010, "sparse_ch1_wrap");
    step(4'b1010, 4'b1000, "sparse_ch3");
    step(4'b1010, 4'b0010, "sparse_ch1");
    step(4'b0000, 4'b0000, "sparse_idle");
    wait_idle("sparse_drain");

    // Back-to-back with latency 1: push and pop coincide in steady state
    set_lat(1);
    for (int k = 0; k < 10; k++) begin
      check("lat1_outstanding", 32'(outstanding), 32'((k < 2) ? k : 2));
      step(4'b0001, 4'b0001, "lat1_grant");
    end
    step(4'b0000, 4'b0000, "lat1_idle");
    wait_idle("lat1_drain");
    check("lat1_final_outstanding", 32'(outstanding), 32'd0);

    // Credit limit with latency 20
    set_lat(20);
    for (int k = 0; k <= 22; k++) begin
      check("credit_outstanding", 32'(outstanding), 32'((k <= 8) ? k : ((k <= 21) ? 8 : 7)));
      step(4'b0001, (k < 8 || k == 22) ? 4'b0001 : 4'b0000, "credit_ready");
    end
    step(4'b0000, 4'b0000, "credit_idle");
    wait_idle("credit_drain");

    // Orphan result sets sticky tag_err
    check("err_before", 32'(tag_err), 32'd0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    check("err_set", 32'(tag_err), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(tag_err), 32'd1);

    // Reset with 5 outstanding, latency 4
    set_lat(4);
    step(4'b1111, 4'b0010, "pre_rst_grant");
    step(4'b1111, 4'b0100, "pre_rst_grant");
    step(4'b1111, 4'b1000, "pre_rst_grant");
    step(4'b1111, 4'b0001, "pre_rst_grant");
    step(4'b1111, 4'b0010, "pre_rst_grant");
    check("pre_rst_outstanding", 32'(outstanding), 32'd5);
    check("pre_rst_calc_valid", 32'(calc_valid_in), 32'd1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(4'b1111, 4'b0000, "redrain_ready");
    step(4'b1111, 4'b0001, "post_rst_grant");
    step(4'b0000, 4'b0000, "post_rst_idle");
    wait_idle("post_rst_drain");
    check("post_rst_tag_err", 32'(tag_err), 32'd0);
    check("post_rst_outstanding", 32'(outstanding), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
